illegal_instruction_trap_unit: RTL and testbench
================================================

# illegal_instruction_trap_unit

Sequential trap sequencer directly downstream of decode's illegal-instruction flag. When decode presents an instruction flagged illegal, this block holds the instruction at decode and waits for all older in-flight instructions to retire. It then raises a precise illegal-instruction exception (mcause 2, mtval = instruction word) to the CSR/exception unit, pulses a pipeline flush and counts trap events.

## Interface

Parameters:
- TVAL_ENABLE, default 1: 1 = exception_tval carries the faulting instruction word; 0 = exception_tval driven to 0.
- COUNT_W, default 32: width of the illegal-trap event counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- decode_valid  in  1  decode holds a valid instruction this cycle
- decode_pc  in  32  PC of the decode instruction
- decode_instruction  in  32  raw instruction word at decode
- illegal_instruction  in  1  decode's illegal flag for decode_instruction (combinational, same cycle)
- retire_empty  in  1  no instructions older than decode are outstanding
- gc_flush  in  1  global flush (branch/interrupt); squashes decode-stage state
- decode_stall  out  1  blocks issue of the decode instruction
- exception_valid  out  1  exception request to CSR unit
- exception_code  out  5  cause; constant ILLEGAL_INST_CODE (2) while valid, else 0
- exception_pc  out  32  captured PC
- exception_tval  out  32  captured instruction word (or 0, see TVAL_ENABLE)
- exception_ack  in  1  CSR unit accepted the request
- trap_flush  out  1  one-cycle pipeline flush pulse after acceptance
- illegal_count  out  COUNT_W  accepted illegal traps since reset; wraps modulo 2^COUNT_W

## Operation

- States: IDLE, DRAIN, REQ, FLUSH (enum in package).
- IDLE: capture when decode_valid & illegal_instruction & ~gc_flush. Latch decode_pc and decode_instruction into holding registers, then go to DRAIN. Otherwise remain in IDLE.
- DRAIN: gc_flush → IDLE with no exception and no count. Else, retire_empty → REQ. Else stay in DRAIN.
- REQ: exception_valid=1. exception_pc/tval/code are held stable until exception_ack. On exception_ack: illegal_count += 1 and go to FLUSH. gc_flush is ignored in REQ because the trap is already precise and committed.
- FLUSH: trap_flush=1 for exactly one cycle, then → IDLE.
- decode_stall = (state != IDLE) | (decode_valid & illegal_instruction). The faulting instruction never issues.
- Outputs exception_pc/tval read 0 outside REQ.
- Reset, and rst asserted in any state: state=IDLE, holding registers=0, illegal_count=0. All outputs 0 the cycle after rst, except decode_stall, which follows its combinational term.

## Timing

- Capture in cycle C → DRAIN at C+1. DRAIN lasts at least one cycle even if retire_empty was already high at C.
- retire_empty high at C+1 → exception_valid at C+2. This is the minimum latency.
- exception_ack sampled in cycle A → trap_flush at A+1 → IDLE at A+2. decode_stall deasserts at A+2 unless a new illegal instruction is presented.
- exception_ack asserted outside REQ is ignored.
- gc_flush in the same cycle as a would-be capture blocks the capture.
- Counter increments on the ack edge only. It wraps from all-ones to 0 with no saturation.

## Structure

- Shared package: state enum trap_state_t {IDLE, DRAIN, REQ, FLUSH} and localparam ILLEGAL_INST_CODE = 5'd2. Both sit alongside the existing exception-cause constants.
- Single flat module: state register, 64-bit holding register, counter. No sub-module is warranted.

## Test plan

- Reset: assert rst with exception_valid pending → next cycle state IDLE, exception_valid=0, trap_flush=0, illegal_count=0.
- Basic trap: decode_valid=1, illegal_instruction=1, pc=0x8000_0010, instr=0xFFFF_FFFF, retire_empty=1 at C → exception_valid at C+2 with code 2, pc 0x8000_0010, tval 0xFFFF_FFFF. Ack at C+4 → trap_flush only at C+5, illegal_count=1, decode_stall low at C+6.
- Drain wait: retire_empty=0 for 10 cycles after capture → exception_valid stays 0 and decode_stall stays 1 throughout. exception_valid rises 1 cycle after retire_empty rises.
- Squash: gc_flush in DRAIN → IDLE next cycle, no exception_valid, illegal_count unchanged. gc_flush coincident with capture → no capture.
- Backpressure: hold exception_ack=0 for 5 REQ cycles while decode_pc/instruction change → exception fields stay at captured values. A gc_flush pulse in REQ is ignored.
- Wrap/param: COUNT_W=2, four accepted traps → count sequence 1,2,3,0. With TVAL_ENABLE=0 → exception_tval=0 in REQ.

Source files
------------

// File: rtl/illegal_instruction_trap_unit_pkg.sv
// Shared exception-cause constants and the illegal-instruction trap sequencer types.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package illegal_instruction_trap_unit_pkg;

  // Machine-mode exception cause codes (mcause, interrupt bit clear).
  localparam logic [4:0] INST_ADDR_MISALIGNED_CODE = 5'd0;
  localparam logic [4:0] INST_ACCESS_FAULT_CODE    = 5'd1;
  localparam logic [4:0] ILLEGAL_INST_CODE         = 5'd2;
  localparam logic [4:0] BREAKPOINT_CODE           = 5'd3;

  // Trap sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REQ   = 2'd2,
    FLUSH = 2'd3
  } trap_state_t;

  // Faulting instruction captured at decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } hold_t;

endpackage

// File: rtl/illegal_instruction_trap_unit.sv
// Turns decode's illegal-instruction flag into a precise exception request, flush pulse and event count.
// Latency: capture at C, exception_valid at C+2 at the earliest; trap_flush one cycle after the ack cycle.
// Backpressure: stalls decode while busy; exception fields hold stable until exception_ack.
//
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   decode_*             instruction at decode plus its combinational illegal flag
//   retire_empty         nothing older than decode is still in flight
//   gc_flush             global flush; drops a trap that is still draining
//   decode_stall         holds the decode instruction (never lets the faulting one issue)
//   exception_*          request to the CSR/exception unit, ack closes the handshake
//   trap_flush           single-cycle pipeline flush after the request is accepted
//   illegal_count        accepted illegal traps since reset, wraps
module illegal_instruction_trap_unit
  import illegal_instruction_trap_unit_pkg::*;
#(
  parameter int unsigned TVAL_ENABLE = 1,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               decode_valid,
  input  logic [31:0]        decode_pc,
  input  logic [31:0]        decode_instruction,
  input  logic               illegal_instruction,
  input  logic               retire_empty,
  input  logic               gc_flush,
  output logic               decode_stall,
  output logic               exception_valid,
  output logic [4:0]         exception_code,
  output logic [31:0]        exception_pc,
  output logic [31:0]        exception_tval,
  input  logic               exception_ack,
  output logic               trap_flush,
  output logic [COUNT_W-1:0] illegal_count
);

  trap_state_t        state_q, state_d;
  hold_t              hold_q;
  logic [COUNT_W-1:0] count_q;
  logic               capture;
  logic               count_inc;
  logic               in_req;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    count_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A global flush in the same cycle kills the decode instruction, so it never traps.
        if (decode_valid && illegal_instruction && !gc_flush) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Older instructions may still redirect the pipe; only a clean drain makes the trap precise.
        if (gc_flush) begin
          state_d = IDLE;
        end else if (retire_empty) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // Trap is committed here: gc_flush is deliberately not looked at.
        if (exception_ack) begin
          count_inc = 1'b1;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hold_q.pc    <= decode_pc;
        hold_q.instr <= decode_instruction;
      end
      if (count_inc) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign in_req = (state_q == REQ);

  // The illegal flag is combinational from decode, so the stall must be too to stop issue at C.
  assign decode_stall    = (state_q != IDLE) | (decode_valid & illegal_instruction);
  assign exception_valid = in_req;
  assign exception_code  = in_req ? ILLEGAL_INST_CODE : 5'd0;
  assign exception_pc    = in_req ? hold_q.pc : 32'd0;
  assign exception_tval  = (in_req && (TVAL_ENABLE != 0)) ? hold_q.instr : 32'd0;
  assign trap_flush      = (state_q == FLUSH);
  assign illegal_count   = count_q;

endmodule

// File: tb/tb_illegal_instruction_trap_unit.sv
module tb_illegal_instruction_trap_unit;

  logic        clk;
  logic        rst;
  logic        decode_valid;
  logic [31:0] decode_pc;
  logic [31:0] decode_instruction;
  logic        illegal_instruction;
  logic        retire_empty;
  logic        gc_flush;
  logic        exception_ack;

  logic        decode_stall;
  logic        exception_valid;
  logic [4:0]  exception_code;
  logic [31:0] exception_pc;
  logic [31:0] exception_tval;
  logic        trap_flush;
  logic [31:0] illegal_count;

  logic        w2_decode_stall;
  logic        w2_exception_valid;
  logic [4:0]  w2_exception_code;
  logic [31:0] w2_exception_pc;
  logic [31:0] w2_exception_tval;
  logic        w2_trap_flush;
  logic [1:0]  w2_illegal_count;

  int total = 0;
  int bad   = 0;

  illegal_instruction_trap_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .decode_valid        (decode_valid),
    .decode_pc           (decode_pc),
    .decode_instruction  (decode_instruction),
    .illegal_instruction (illegal_instruction),
    .retire_empty        (retire_empty),
    .gc_flush            (gc_flush),
    .decode_stall        (decode_stall),
    .exception_valid     (exception_valid),
    .exception_code      (exception_code),
    .exception_pc        (exception_pc),
    .exception_tval      (exception_tval),
    .exception_ack       (exception_ack),
    .trap_flush          (trap_flush),
    .illegal_count       (illegal_count)
  );

  illegal_instruction_trap_unit #(.TVAL_ENABLE(0), .COUNT_W(2)) dut_w2 (
    .clk                 (clk),
    .rst                 (rst),
    .decode_valid        (decode_valid),
    .decode_pc           (decode_pc),
    .decode_instruction  (decode_instruction),
    .illegal_instruction (illegal_instruction),
    .retire_empty        (retire_empty),
    .gc_flush            (gc_flush),
    .decode_stall        (w2_decode_stall),
    .exception_valid     (w2_exception_valid),
    .exception_code      (w2_exception_code),
    .exception_pc        (w2_exception_pc),
    .exception_tval      (w2_exception_tval),
    .exception_ack       (exception_ack),
    .trap_flush          (w2_trap_flush),
    .illegal_count       (w2_illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an illegal instruction at decode for one cycle (caller then ticks).
  task automatic present(input logic [31:0] pc, input logic [31:0] ins);
    decode_valid        = 1'b1;
    illegal_instruction = 1'b1;
    decode_pc           = pc;
    decode_instruction  = ins;
  endtask

  task automatic clear_decode();
    decode_valid        = 1'b0;
    illegal_instruction = 1'b0;
  endtask

  logic [1:0] wrap_exp [4];

  initial begin
    rst                 = 1'b1;
    decode_valid        = 1'b0;
    decode_pc           = 32'd0;
    decode_instruction  = 32'd0;
    illegal_instruction = 1'b0;
    retire_empty        = 1'b0;
    gc_flush            = 1'b0;
    exception_ack       = 1'b0;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0;

    tick(); tick();
    rst = 1'b0;
    tick(); #1;
    chk("reset_valid", {63'd0, exception_valid}, 64'd0);
    chk("reset_flush", {63'd0, trap_flush}, 64'd0);
    chk("reset_count", {32'd0, illegal_count}, 64'd0);
    chk("reset_stall", {63'd0, decode_stall}, 64'd0);
    chk("reset_pc", {32'd0, exception_pc}, 64'd0);

    // Basic trap, minimum latency. Cycle C.
    retire_empty  = 1'b1;
    exception_ack = 1'b1;   // ack outside REQ must be ignored
    present(32'h8000_0010, 32'hFFFF_FFFF);
    #1;
    chk("basic_stall_C", {63'd0, decode_stall}, 64'd1);
    tick();                 // C+1 (DRAIN)
    exception_ack = 1'b0;
    clear_decode();
    #1;
    chk("basic_valid_C1", {63'd0, exception_valid}, 64'd0);
    chk("basic_stall_C1", {63'd0, decode_stall}, 64'd1);
    chk("ack_idle_ignored", {32'd0, illegal_count}, 64'd0);
    tick(); #1;             // C+2 (REQ)
    chk("basic_valid_C2", {63'd0, exception_valid}, 64'd1);
    chk("basic_code", {59'd0, exception_code}, 64'd2);
    chk("basic_pc", {32'd0, exception_pc}, 64'h8000_0010);
    chk("basic_tval", {32'd0, exception_tval}, 64'hFFFF_FFFF);
    chk("w2_tval_zero", {32'd0, w2_exception_tval}, 64'd0);
    chk("w2_pc", {32'd0, w2_exception_pc}, 64'h8000_0010);
    tick(); #1;             // C+3
    chk("basic_flush_C3", {63'd0, trap_flush}, 64'd0);
    tick();                 // C+4: ack
    exception_ack = 1'b1;
    #1;
    chk("basic_count_C4", {32'd0, illegal_count}, 64'd0);
    tick();                 // C+5 (FLUSH)
    exception_ack = 1'b0;
    #1;
    chk("basic_flush_C5", {63'd0, trap_flush}, 64'd1);
    chk("basic_valid_C5", {63'd0, exception_valid}, 64'd0);
    chk("basic_count_C5", {32'd0, illegal_count}, 64'd1);
    chk("basic_pc_C5", {32'd0, exception_pc}, 64'd0);
    chk("basic_stall_C5", {63'd0, decode_stall}, 64'd1);
    tick(); #1;             // C+6 (IDLE)
    chk("basic_flush_C6", {63'd0, trap_flush}, 64'd0);
    chk("basic_stall_C6", {63'd0, decode_stall}, 64'd0);

    // Drain wait: retire_empty low for 10 cycles after capture.
    retire_empty = 1'b0;
    present(32'h0000_1000, 32'h0000_0073);
    for (int i = 1; i <= 10; i++) begin
      tick();
      clear_decode();
      if (i == 10) retire_empty = 1'b1;
      #1;
      chk($sformatf("drain_valid_%0d", i), {63'd0, exception_valid}, 64'd0);
      chk($sformatf("drain_stall_%0d", i), {63'd0, decode_stall}, 64'd1);
    end
    tick(); #1;
    chk("drain_valid_rise", {63'd0, exception_valid}, 64'd1);
    chk("drain_pc", {32'd0, exception_pc}, 64'h0000_1000);
    exception_ack = 1'b1;
    tick();
    exception_ack = 1'b0;
    #1;
    chk("drain_count", {32'd0, illegal_count}, 64'd2);
    tick();

    // Squash in DRAIN.
    retire_empty = 1'b0;
    present(32'h0000_2000, 32'h1234_5678);
    tick();                 // DRAIN
    clear_decode();
    gc_flush = 1'b1;
    tick();                 // back to IDLE
    gc_flush     = 1'b0;
    retire_empty = 1'b1;
    #1;
    chk("squash_stall", {63'd0, decode_stall}, 64'd0);
    chk("squash_valid", {63'd0, exception_valid}, 64'd0);
    tick(); tick(); #1;
    chk("squash_valid_late", {63'd0, exception_valid}, 64'd0);
    chk("squash_count", {32'd0, illegal_count}, 64'd2);

    // gc_flush coincident with capture blocks it.
    present(32'h0000_3000, 32'hDEAD_BEEF);
    gc_flush = 1'b1;
    #1;
    chk("coinc_stall_comb", {63'd0, decode_stall}, 64'd1);
    tick();
    clear_decode();
    gc_flush = 1'b0;
    #1;
    chk("coinc_stall", {63'd0, decode_stall}, 64'd0);
    tick(); tick(); #1;
    chk("coinc_valid", {63'd0, exception_valid}, 64'd0);

    // Backpressure: fields hold while decode inputs move; gc_flush ignored in REQ.
    present(32'h0000_4444, 32'hCAFE_0001);
    tick();
    clear_decode();
    tick();                 // REQ
    for (int i = 0; i < 5; i++) begin
      decode_valid       = 1'b1;
      decode_pc          = $urandom;
      decode_instruction = $urandom;
      gc_flush           = (i == 2);
      #1;
      chk($sformatf("bp_valid_%0d", i), {63'd0, exception_valid}, 64'd1);
      chk($sformatf("bp_pc_%0d", i), {32'd0, exception_pc}, 64'h0000_4444);
      chk($sformatf("bp_tval_%0d", i), {32'd0, exception_tval}, 64'hCAFE_0001);
      chk($sformatf("bp_code_%0d", i), {59'd0, exception_code}, 64'd2);
      tick();
    end
    gc_flush      = 1'b0;
    decode_valid  = 1'b0;
    exception_ack = 1'b1;
    #1;
    chk("bp_valid_final", {63'd0, exception_valid}, 64'd1);
    tick();
    exception_ack = 1'b0;
    #1;
    chk("bp_flush", {63'd0, trap_flush}, 64'd1);
    chk("bp_count", {32'd0, illegal_count}, 64'd3);
    tick();

    // Reset while a request is pending.
    present(32'h0000_5000, 32'h0000_0001);
    tick();
    clear_decode();
    tick(); #1;
    chk("rst_pre_valid", {63'd0, exception_valid}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {63'd0, exception_valid}, 64'd0);
    chk("rst_flush", {63'd0, trap_flush}, 64'd0);
    chk("rst_count", {32'd0, illegal_count}, 64'd0);
    chk("rst_stall", {63'd0, decode_stall}, 64'd0);

    // Four accepted traps: narrow counter wraps 1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      present(32'h0000_6000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i));
      tick();
      clear_decode();
      tick();               // REQ
      exception_ack = 1'b1;
      #1;
      chk($sformatf("wrap_valid_%0d", i), {63'd0, w2_exception_valid}, 64'd1);
      chk($sformatf("wrap_tval_%0d", i), {32'd0, w2_exception_tval}, 64'd0);
      tick();               // FLUSH
      exception_ack = 1'b0;
      #1;
      chk($sformatf("wrap_count_%0d", i), {62'd0, w2_illegal_count}, {62'd0, wrap_exp[i]});
      chk($sformatf("wide_count_%0d", i), {32'd0, illegal_count}, 64'(i + 1));
      chk($sformatf("wrap_flush_%0d", i), {63'd0, w2_trap_flush}, 64'd1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
